// File: rtl/cp0_exception_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exception_unit_pkg
//  Description : Shared definitions for the CP0 / precise-exception unit:
//                exception-type encodings carried down the pipeline, MIPS
//                ExcCode values, CP0 register numbers, Status/Cause bit
//                positions and reset/constant register values.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_exception_unit_pkg;

  // Exception type carried from decode/ALU into MEM.
  localparam int EXC_TYPE_LENGTH = 4;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_NONE = 4'd0;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_TR   = 4'd1;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_OV   = 4'd2;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_SYS  = 4'd3;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_BP   = 4'd4;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_RI   = 4'd5;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ADEL = 4'd6;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ADES = 4'd7;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ERET = 4'd8;
  // Only ever produced by this unit (reported on exc_type_taken).
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_INT  = 4'd9;

  // Cause.ExcCode values.
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;

  // CP0 register numbers.
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // Status / Cause bit positions.
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;

  // Register constants.
  localparam logic [31:0] STATUS_RESET       = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK       = 32'h0040_FF03;  // BEV, IM, EXL, IE
  localparam logic [31:0] PRID_VALUE         = 32'h0000_4220;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  function automatic logic [4:0] exc_code_of(input logic [EXC_TYPE_LENGTH-1:0] t);
    logic [4:0] code;
    code = EXCCODE_INT;
    case (t)
      EXC_TYPE_TR:   code = EXCCODE_TR;
      EXC_TYPE_OV:   code = EXCCODE_OV;
      EXC_TYPE_SYS:  code = EXCCODE_SYS;
      EXC_TYPE_BP:   code = EXCCODE_BP;
      EXC_TYPE_RI:   code = EXCCODE_RI;
      EXC_TYPE_ADEL: code = EXCCODE_ADEL;
      EXC_TYPE_ADES: code = EXCCODE_ADES;
      default:       code = EXCCODE_INT;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_exception_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer
//  Description : CP0 Count/Compare timer. Count free-runs (wrapping), an
//                mtc0 to Count replaces that cycle's increment. The timer
//                interrupt flag sets on the cycle after Count==Compare
//                (Compare!=0) and is cleared only by an mtc0 to Compare.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                i_count_we          - mtc0 Count strobe
//                i_compare_we        - mtc0 Compare strobe
//                i_wdata             - mtc0 data
//                o_count, o_compare  - current register values
//                o_timer_int         - Cause.TI
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timer_int
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= i_count_we ? i_wdata : r_count + 32'd1;
      if (i_compare_we)
        r_compare <= i_wdata;
      // Writing Compare acknowledges the timer even if it matches this cycle.
      if (i_compare_we)
        r_ti <= 1'b0;
      else if ((r_count == r_compare) && (r_compare != 32'd0))
        r_ti <= 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_compare   = r_compare;
  assign o_timer_int = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exception_unit
//  Description : MEM-stage coprocessor 0 and precise-exception unit.
//                Arbitrates interrupts > instruction exceptions > ERET,
//                commits EPC/Cause/Status/BadVAddr, drives flush/redirect,
//                services mfc0/mtc0 and hosts the Count/Compare timer.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                mem_valid, exc_type_in,
//                mem_pc, mem_in_delay_slot,
//                mem_bad_vaddr              - MEM-stage instruction info
//                hw_int                     - level interrupt lines
//                cp0_we/waddr/wdata         - mtc0 port
//                cp0_raddr/rdata            - mfc0 port (combinational)
//                flush, exc_pc,
//                exc_type_taken             - redirect (combinational)
//                status_o, cause_o, epc_o   - register views
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = EXC_VECTOR_DEFAULT,
  parameter int          TIMER_IRQ_LINE = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_valid,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_type_in,
  input  logic [31:0]                mem_pc,
  input  logic                       mem_in_delay_slot,
  input  logic [31:0]                mem_bad_vaddr,
  input  logic [5:0]                 hw_int,
  input  logic                       cp0_we,
  input  logic [4:0]                 cp0_waddr,
  input  logic [31:0]                cp0_wdata,
  input  logic [4:0]                 cp0_raddr,
  output logic [31:0]                cp0_rdata,
  output logic                       flush,
  output logic [31:0]                exc_pc,
  output logic [EXC_TYPE_LENGTH-1:0] exc_type_taken,
  output logic [31:0]                status_o,
  output logic [31:0]                cause_o,
  output logic [31:0]                epc_o
);

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;
  logic [5:0]  w_hw_irq;
  logic        w_int_pending;
  logic        w_has_exc;
  logic        w_is_eret;
  logic        w_take_int;
  logic        w_take_exc;
  logic        w_take_eret;
  logic        w_take_any;
  logic        w_wr;
  logic        w_is_addr_exc;
  logic [4:0]  w_exc_code;

  assign w_ip    = {r_ip_hw, r_ip_sw};
  assign w_cause = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

  assign w_int_pending = mem_valid & r_status[STATUS_IE] & ~r_status[STATUS_EXL]
                       & (|(w_ip & r_status[15:8]));
  assign w_is_eret     = (exc_type_in == EXC_TYPE_ERET);
  assign w_has_exc     = (exc_type_in != EXC_TYPE_NONE) & ~w_is_eret;

  // Gating with rst_n lets flush drop the instant reset asserts, without
  // waiting for the registered state to settle.
  assign w_take_int  = rst_n & w_int_pending;
  assign w_take_exc  = rst_n & mem_valid & ~w_int_pending & w_has_exc;
  assign w_take_eret = rst_n & mem_valid & ~w_int_pending & w_is_eret;
  assign w_take_any  = w_take_int | w_take_exc;

  assign flush = w_take_any | w_take_eret;
  // A flushed (faulting) instruction does not retire, so its mtc0 is dropped.
  assign w_wr  = cp0_we & ~flush;

  assign w_hw_irq      = hw_int | ({5'd0, w_ti} << TIMER_IRQ_LINE);
  assign w_is_addr_exc = (exc_type_in == EXC_TYPE_ADEL) | (exc_type_in == EXC_TYPE_ADES);
  assign w_exc_code    = w_take_int ? EXCCODE_INT : exc_code_of(exc_type_in);

  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_count_we   (w_wr && (cp0_waddr == CP0_COUNT)),
    .i_compare_we (w_wr && (cp0_waddr == CP0_COMPARE)),
    .i_wdata      (cp0_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_timer_int  (w_ti)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status   <= STATUS_RESET;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_bd       <= 1'b0;
      r_ip_hw    <= 6'd0;
      r_ip_sw    <= 2'd0;
      r_exccode  <= 5'd0;
    end else begin
      r_ip_hw <= w_hw_irq;
      if (w_take_any) begin
        // Nested exceptions keep the original return point.
        if (!r_status[STATUS_EXL]) begin
          r_epc <= mem_in_delay_slot ? (mem_pc - 32'd4) : mem_pc;
          r_bd  <= mem_in_delay_slot;
        end
        r_status[STATUS_EXL] <= 1'b1;
        r_exccode            <= w_exc_code;
        if (w_take_exc && w_is_addr_exc)
          r_badvaddr <= mem_bad_vaddr;
      end else if (w_take_eret) begin
        r_status[STATUS_EXL] <= 1'b0;
      end
      // w_wr is never set together with a take, so these cannot collide.
      if (w_wr) begin
        case (cp0_waddr)
          CP0_STATUS: r_status <= cp0_wdata & STATUS_WMASK;
          CP0_CAUSE:  r_ip_sw  <= cp0_wdata[9:8];
          CP0_EPC:    r_epc    <= cp0_wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = r_badvaddr;
      CP0_COUNT:    cp0_rdata = w_count;
      CP0_COMPARE:  cp0_rdata = w_compare;
      CP0_STATUS:   cp0_rdata = r_status;
      CP0_CAUSE:    cp0_rdata = w_cause;
      CP0_EPC:      cp0_rdata = r_epc;
      CP0_PRID:     cp0_rdata = PRID_VALUE;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  always_comb begin
    exc_pc         = 32'd0;
    exc_type_taken = EXC_TYPE_NONE;
    if (w_take_int) begin
      exc_pc         = EXC_VECTOR;
      exc_type_taken = EXC_TYPE_INT;
    end else if (w_take_exc) begin
      exc_pc         = EXC_VECTOR;
      exc_type_taken = exc_type_in;
    end else if (w_take_eret) begin
      exc_pc         = r_epc;
      exc_type_taken = EXC_TYPE_ERET;
    end
  end

  assign status_o = r_status;
  assign cause_o  = w_cause;
  assign epc_o    = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_exception_unit
//  Description : Self-checking bench for cp0_exception_unit: directed
//                scenarios followed by randomized traffic, all compared
//                every cycle against a field-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_unit;
  import cp0_exception_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [3:0]  exc_type_in;
  logic [31:0] mem_pc;
  logic        mem_in_delay_slot;
  logic [31:0] mem_bad_vaddr;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic [31:0] exc_pc;
  logic [3:0]  exc_type_taken;
  logic [31:0] status_o, cause_o, epc_o;

  always #5 clk = ~clk;

  cp0_exception_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .exc_type_in(exc_type_in),
    .mem_pc(mem_pc), .mem_in_delay_slot(mem_in_delay_slot),
    .mem_bad_vaddr(mem_bad_vaddr), .hw_int(hw_int), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
    .cp0_rdata(cp0_rdata), .flush(flush), .exc_pc(exc_pc),
    .exc_type_taken(exc_type_taken), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural fields kept separately.
  logic [31:0] m_count, m_compare, m_epc, m_bad;
  logic        m_ti, m_bd, m_bev, m_exl, m_ie;
  logic [7:0]  m_im;
  logic [5:0]  m_ip_hw;
  logic [1:0]  m_ip_sw;
  logic [4:0]  m_code;
  int          code_tbl [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_epc = 0; m_bad = 0;
    m_ti = 0; m_bd = 0; m_bev = 1; m_exl = 0; m_ie = 0;
    m_im = 0; m_ip_hw = 0; m_ip_sw = 0; m_code = 0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 0;
    s[22] = m_bev; s[15:8] = m_im; s[1] = m_exl; s[0] = m_ie;
    return s;
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = 0;
    c[31] = m_bd; c[30] = m_ti; c[15:10] = m_ip_hw; c[9:8] = m_ip_sw; c[6:2] = m_code;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      default: return 32'd0;
    endcase
  endfunction

  // 0 nothing, 1 interrupt, 2 instruction exception, 3 eret
  function automatic int take_kind();
    if (!rst_n || !mem_valid) return 0;
    if (m_ie && !m_exl && (({m_ip_hw, m_ip_sw} & m_im) != 8'd0)) return 1;
    if (exc_type_in == EXC_TYPE_ERET) return 3;
    if (exc_type_in != EXC_TYPE_NONE) return 2;
    return 0;
  endfunction

  task automatic advance();
    int k; logic wr; logic [5:0] nh; logic nti;
    if (!rst_n) begin model_reset(); return; end
    k  = take_kind();
    wr = cp0_we && (k == 0);
    nh = hw_int;
    if (m_ti) nh[5] = 1'b1;
    nti = m_ti;
    if (wr && cp0_waddr == 5'd11) nti = 1'b0;
    else if (m_count == m_compare && m_compare != 0) nti = 1'b1;
    if (wr && cp0_waddr == 5'd9) m_count = cp0_wdata; else m_count = m_count + 1;
    if (wr && cp0_waddr == 5'd11) m_compare = cp0_wdata;
    m_ip_hw = nh; m_ti = nti;
    if (k == 1 || k == 2) begin
      if (!m_exl) begin
        m_epc = mem_in_delay_slot ? mem_pc - 4 : mem_pc;
        m_bd  = mem_in_delay_slot;
      end
      m_exl  = 1'b1;
      m_code = (k == 1) ? 5'd0 : 5'(code_tbl[exc_type_in]);
      if (k == 2 && (exc_type_in == EXC_TYPE_ADEL || exc_type_in == EXC_TYPE_ADES))
        m_bad = mem_bad_vaddr;
    end
    if (k == 3) m_exl = 1'b0;
    if (wr) begin
      case (cp0_waddr)
        5'd12: begin m_bev = cp0_wdata[22]; m_im = cp0_wdata[15:8];
                     m_exl = cp0_wdata[1];  m_ie = cp0_wdata[0]; end
        5'd13: m_ip_sw = cp0_wdata[9:8];
        5'd14: m_epc = cp0_wdata;
        default: ;
      endcase
    end
  endtask

  // One clock: compare every output against the model mid-cycle, then step both.
  task automatic cycle();
    int k;
    logic [31:0] e_pc; logic [3:0] e_ty;
    @(negedge clk);
    k = take_kind();
    e_pc = (k == 3) ? m_epc : (k != 0) ? 32'hBFC0_0380 : 32'd0;
    e_ty = (k == 1) ? EXC_TYPE_INT : (k == 2) ? exc_type_in : (k == 3) ? EXC_TYPE_ERET : EXC_TYPE_NONE;
    check("flush", 32'(flush), 32'(k != 0));
    check("exc_pc", exc_pc, e_pc);
    check("exc_type_taken", 32'(exc_type_taken), 32'(e_ty));
    check("cp0_rdata", cp0_rdata, m_read(cp0_raddr));
    check("status_o", status_o, m_status());
    check("cause_o", cause_o, m_cause());
    check("epc_o", epc_o, m_epc);
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; exc_type_in = EXC_TYPE_NONE; mem_in_delay_slot = 0;
    cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    cycle();
    cp0_we = 0;
  endtask

  initial begin
    logic ti_seen;
    logic [31:0] r;
    code_tbl = '{default: 0};
    code_tbl[EXC_TYPE_TR] = 13;  code_tbl[EXC_TYPE_OV] = 12;
    code_tbl[EXC_TYPE_SYS] = 8;  code_tbl[EXC_TYPE_BP] = 9;
    code_tbl[EXC_TYPE_RI] = 10;  code_tbl[EXC_TYPE_ADEL] = 4;
    code_tbl[EXC_TYPE_ADES] = 5;
    model_reset();

    // Reset held with a would-be exception present: nothing may be raised.
    rst_n = 0; idle(); hw_int = 0; mem_pc = 0; mem_bad_vaddr = 0; cp0_raddr = 5'd12;
    mem_valid = 1; exc_type_in = EXC_TYPE_OV;
    cycle(); cycle();
    check("reset_status", status_o, 32'h0040_0000);
    check("reset_flush", 32'(flush), 32'd0);

    // Release reset; Count must read 2 after two edges.
    idle(); rst_n = 1; cp0_raddr = 5'd9;
    cycle(); cycle();
    check("count_after_2", cp0_rdata, 32'd2);

    // OV, not in a delay slot.
    mem_valid = 1; exc_type_in = EXC_TYPE_OV; mem_pc = 32'h8000_0100; cp0_raddr = 5'd13;
    #1;
    check("ov_flush", 32'(flush), 32'd1);
    check("ov_exc_pc", exc_pc, 32'hBFC0_0380);
    cycle(); idle();
    check("ov_epc", epc_o, 32'h8000_0100);
    check("ov_code", 32'(cause_o[6:2]), 32'd12);
    check("ov_exl", 32'(status_o[1]), 32'd1);

    // TR in a delay slot, then ERET back.
    mtc0(5'd12, 32'h0);
    mem_valid = 1; exc_type_in = EXC_TYPE_TR; mem_pc = 32'h8000_0204; mem_in_delay_slot = 1;
    cycle(); idle();
    check("tr_epc", epc_o, 32'h8000_0200);
    check("tr_bd", 32'(cause_o[31]), 32'd1);
    check("tr_code", 32'(cause_o[6:2]), 32'd13);
    mem_valid = 1; exc_type_in = EXC_TYPE_ERET;
    #1;
    check("eret_pc", exc_pc, 32'h8000_0200);
    cycle(); idle();
    check("eret_exl", 32'(status_o[1]), 32'd0);

    // Interrupt beats OV; a bubble raises nothing.
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    cycle(); cycle();
    check("bubble_no_flush", 32'(flush), 32'd0);
    mem_valid = 1; exc_type_in = EXC_TYPE_OV; mem_pc = 32'h8000_0400;
    #1;
    check("int_type", 32'(exc_type_taken), 32'(EXC_TYPE_INT));
    cycle(); idle(); hw_int = 0;
    check("int_code", 32'(cause_o[6:2]), 32'd0);
    check("int_epc", epc_o, 32'h8000_0400);
    mtc0(5'd12, 32'h0);

    // Timer: Compare=20, Count=0 -> TI after Count passes 20.
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    cp0_raddr = 5'd9; ti_seen = 0;
    for (int i = 0; i < 40 && !ti_seen; i++) begin
      cycle();
      if (cause_o[30]) ti_seen = 1;
    end
    check("ti_rise", 32'(ti_seen), 32'd1);
    check("ti_count", cp0_rdata, 32'd21);
    mtc0(5'd11, 32'd100);
    check("ti_clear", 32'(cause_o[30]), 32'd0);

    // Nested OV with EXL=1 and a same-cycle mtc0 EPC that must be dropped.
    mtc0(5'd12, 32'h0000_0002);
    mem_valid = 1; exc_type_in = EXC_TYPE_OV; mem_pc = 32'h8000_0300;
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    cycle(); idle();
    check("nested_epc", epc_o, 32'h8000_0400);
    check("nested_code", 32'(cause_o[6:2]), 32'd12);
    mtc0(5'd12, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int t;
      logic [4:0] addrs [8];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'($urandom)};
      t = $urandom % 12;
      if (t > 8) t = 0;
      mem_valid         = ($urandom % 4) != 0;
      exc_type_in       = 4'(t);
      mem_pc            = $urandom & 32'hFFFF_FFFC;
      mem_in_delay_slot = $urandom % 2;
      mem_bad_vaddr     = $urandom;
      hw_int            = ($urandom % 6 == 0) ? 6'($urandom) : 6'd0;
      cp0_we            = ($urandom % 3) == 0;
      cp0_waddr         = addrs[$urandom % 8];
      cp0_wdata         = ($urandom % 2) ? $urandom : $urandom_range(0, 40);
      cp0_raddr         = addrs[$urandom % 8];
      cycle();
    end

    // Asynchronous reset mid-operation.
    mem_valid = 1; exc_type_in = EXC_TYPE_OV; cp0_we = 0;
    rst_n = 0; model_reset();
    #1;
    check("async_flush", 32'(flush), 32'd0);
    check("async_status", status_o, 32'h0040_0000);
    check("async_epc", epc_o, 32'd0);
    r = cause_o;
    check("async_cause", r, 32'd0);
    cycle();
    idle(); rst_n = 1;
    cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 and precise-exception unit in the MEM stage; the consumer of exc_type produced by the ALU and decode stages (TR, OV, SYS, BP, RI, ADEL, ADES, ERET).
- Prioritises pending hardware/timer interrupts over instruction exceptions, commits EPC/Cause/Status/BadVAddr, and drives pipeline flush with redirect PC.
- Services mfc0/mtc0 and runs the Count/Compare timer.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception/interrupt
- TIMER_IRQ_LINE, 5, hw interrupt index (IP[7]) driven by timer

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  valid instruction in MEM (not bubble/flushed)
- exc_type_in  in  EXC_TYPE_LENGTH  exception type from ALU/earlier stages
- mem_pc  in  32  PC of MEM instruction
- mem_in_delay_slot  in  1  MEM instruction is in a branch delay slot
- mem_bad_vaddr  in  32  faulting address for ADEL/ADES
- hw_int  in  6  external interrupt lines, level-sensitive
- cp0_we  in  1  mtc0 write strobe
- cp0_waddr  in  5  mtc0 register number
- cp0_wdata  in  32  mtc0 data
- cp0_raddr  in  5  mfc0 register number
- cp0_rdata  out  32  mfc0 data, combinational
- flush  out  1  flush IF..MEM, combinational
- exc_pc  out  32  redirect PC, valid when flush=1
- exc_type_taken  out  EXC_TYPE_LENGTH  committed type (NONE when no flush)
- status_o, cause_o, epc_o  out  32 each  current register values

Behaviour:
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12: IM[15:8], EXL[1], IE[0], BEV[22]), Cause(13: BD[31], TI[30], IP[15:8], ExcCode[6:2]), EPC(14), PRId(15)=32'h00004220 const. Other addresses read 0, writes ignored.
- Reset: Status=32'h00400000, all other registers 0; flush=0, exc_pc=0, exc_type_taken=NONE.
- Count +1 every cycle, wraps 0xFFFFFFFF->0. mtc0 Count replaces increment that cycle.
- TI set on cycle after Count==Compare with Compare!=0; cleared only by mtc0 Compare (clear wins over same-cycle match).
- IP[7:2] registered each cycle from {hw_int[5] | TI, hw_int[4:0]} (timer ORed onto TIMER_IRQ_LINE); IP[1:0] software-writable via mtc0 Cause; all other Cause bits read-only to mtc0.
- int_pending = mem_valid & IE & ~EXL & |(IP & IM).
- Priority, same cycle: int_pending > exc_type_in (!= NONE, !=ERET) > ERET. Only with mem_valid=1; bubbles never raise anything.
- Take exception: flush=1, exc_pc=EXC_VECTOR that cycle. Next edge: if EXL==0 then EPC = in_delay_slot ? mem_pc-4 : mem_pc, BD = in_delay_slot; EXL<=1 always; ExcCode <= Int0/AdEL4/AdES5/Sys8/Bp9/RI10/Ov12/Tr13; BadVAddr <= mem_bad_vaddr for ADEL/ADES only.
- Nested exception (EXL=1): EPC, BD unchanged; ExcCode/BadVAddr updated.
- ERET: flush=1, exc_pc=EPC (pre-edge value); EXL<=0 at edge.
- mtc0 in same cycle as flush: write discarded (faulting instruction does not retire). Otherwise write lands at edge; mfc0 reads pre-edge value (no bypass; pipeline interlocks).
- Reset mid-operation: all state to reset values immediately, flush deasserts asynchronously.

Decomposition:
- definitions.v: EXC_TYPE_INT/SYS/BP/RI/ADEL/ADES/ERET/NONE (extending existing TR/OV), ExcCode values, CP0 register numbers, Status/Cause bit positions, EXC_VECTOR default.
- Sub-module cp0_timer: Count/Compare/TI with mtc0 write ports.

Test Plan:
- Reset then mfc0 12 -> 32'h00400000; mfc0 9 two cycles later -> 2.
- exc_type_in=OV, mem_pc=32'h80000100, not in delay slot -> flush=1, exc_pc=32'hBFC00380; next cycle EPC=32'h80000100, ExcCode=12, EXL=1.
- TR in delay slot at pc 32'h80000204 -> EPC=32'h80000200, BD=1, ExcCode=13; then ERET -> exc_pc=32'h80000200, EXL=0.
- Status=32'h00000401 (IM2, IE), hw_int=6'b000001 -> interrupt taken over simultaneous OV; ExcCode=0; with mem_valid=0 nothing taken.
- mtc0 Compare=20, Count=0 -> TI=1 when Count passes 20; mtc0 Compare=100 -> TI=0.
- OV with EXL=1 -> EPC unchanged, ExcCode=12; mtc0 EPC in flush cycle discarded.
